cmd_dispatch: RTL and testbench

//  Parametrised successor of the opcode->CMD pulse decoder. Buffers incoming command packets in a small
//  in-order FIFO, decodes the head opcode to a channel, and holds it until that unit's BUSY clears instead of

---
 rtl/cmd_dispatch_if.sv | 34 +++
 rtl/cmd_dispatch.sv | 144 ++++++++++++++
 tb/tb_cmd_dispatch.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_dispatch_if.sv
// Command dispatcher bus: packet input, per-unit busy, control strobes,
// issue pulses and status/error reporting, grouped for the dispatcher port.
interface cmd_dispatch_if #(
    parameter int NUM_CH     = 8,
    parameter int OP_W       = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic              packet_ready;
    logic [OP_W-1:0]   opcode;
    logic [NUM_CH-1:0] BUSY;
    logic              flush;
    logic              err_clr;
    logic [NUM_CH-1:0] CMD;
    logic              pkt_accept;
    logic [LVL_W-1:0]  fifo_level;
    logic              err_unknown;
    logic              err_overflow;
    logic              err_timeout;
    logic [OP_W-1:0]   err_opcode;

    // Packet source / unit side
    modport master (
        output packet_ready, opcode, BUSY, flush, err_clr,
        input  CMD, pkt_accept, fifo_level, err_unknown, err_overflow, err_timeout, err_opcode
    );

    // Dispatcher side
    modport slave (
        input  packet_ready, opcode, BUSY, flush, err_clr,
        output CMD, pkt_accept, fifo_level, err_unknown, err_overflow, err_timeout, err_opcode
    );
endinterface

// File: rtl/cmd_dispatch.sv
// Command dispatcher: queues opcodes in an in-order FIFO, decodes the head to
// a channel and issues a one-cycle CMD pulse once that unit is free. Unknown
// opcodes and heads stalled too long are discarded with sticky error flags.
module cmd_dispatch #(
    parameter int                NUM_CH      = 8,
    parameter int                OP_W        = 8,
    parameter int                OP_BASE     = 1,
    parameter logic [NUM_CH-1:0] VALID_MASK  = 8'hF7,
    parameter logic [NUM_CH-1:0] BYPASS_MASK = 8'h01,
    parameter int                FIFO_DEPTH  = 4,
    parameter int                TIMEOUT     = 1024
) (
    input logic           CLK,
    input logic           rst,
    cmd_dispatch_if.slave bus
);
    localparam int PTR_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1;
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int STALL_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int STALL_MAX_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_MAX_I);

    logic [OP_W-1:0]    r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_count;
    logic [STALL_W-1:0] r_stall;
    logic [NUM_CH-1:0]  r_holdoff;
    logic [NUM_CH-1:0]  r_cmd;
    logic               r_err_unk;
    logic               r_err_ovf;
    logic               r_err_to;
    logic [OP_W-1:0]    r_err_op;

    logic               w_empty;
    logic               w_full;
    logic [OP_W-1:0]    w_head;
    logic [OP_W:0]      w_diff;
    logic               w_in_range;
    logic [CH_W-1:0]    w_ch;
    logic               w_known;
    logic               w_active;
    logic               w_can_issue;
    logic               w_issue;
    logic               w_unknown;
    logic               w_blocked;
    logic               w_timeout;
    logic               w_pop;
    logic               w_push;
    logic               w_overflow;
    logic [NUM_CH-1:0]  w_issue_vec;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == LVL_W'(FIFO_DEPTH));
    assign w_head  = r_mem[r_rd_ptr];

    // Channel index computed one bit wider so opcodes below OP_BASE cannot wrap into range
    assign w_diff     = {1'b0, w_head} - (OP_W+1)'(OP_BASE);
    assign w_in_range = ({1'b0, w_head} >= (OP_W+1)'(OP_BASE)) && (w_diff < (OP_W+1)'(NUM_CH));
    assign w_ch       = w_diff[CH_W-1:0];
    assign w_known    = w_in_range && VALID_MASK[w_ch];

    // Flush pre-empts every head action in its cycle
    assign w_active    = !w_empty && !bus.flush;
    assign w_can_issue = BYPASS_MASK[w_ch] || (!bus.BUSY[w_ch] && !r_holdoff[w_ch]);
    assign w_issue     = w_active && w_known && w_can_issue;
    assign w_unknown   = w_active && !w_known;
    assign w_blocked   = w_active && w_known && !w_can_issue;
    assign w_timeout   = (TIMEOUT != 0) && w_blocked && (r_stall == STALL_MAX);
    assign w_pop       = w_issue || w_unknown || w_timeout;

    // Full is judged on registered state only, so a pop never makes room for a same-cycle push
    assign w_push     = bus.packet_ready && !w_full && !bus.flush;
    assign w_overflow = bus.packet_ready && w_full && !bus.flush;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_issue
            assign w_issue_vec[gi] = w_issue && (w_ch == CH_W'(gi));
        end
    endgenerate

    // Queue storage: written at the tail, no reset needed since occupancy is tracked separately
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.opcode;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge CLK) begin
        if (rst || bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + LVL_W'(w_push) - LVL_W'(w_pop);
        end
    end

    // Issue pulse, one-cycle hold-off for the just-issued channel, and head stall counter
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_cmd     <= '0;
            r_holdoff <= '0;
            r_stall   <= '0;
        end else begin
            r_cmd     <= w_issue_vec;
            r_holdoff <= w_issue_vec;
            if (bus.flush || w_pop) begin
                r_stall <= '0;
            end else if (w_blocked) begin
                r_stall <= r_stall + STALL_W'(1);
            end
        end
    end

    // Sticky error flags; a new event outranks a same-cycle clear
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_err_unk <= 1'b0;
            r_err_ovf <= 1'b0;
            r_err_to  <= 1'b0;
            r_err_op  <= '0;
        end else begin
            r_err_unk <= w_unknown  || (r_err_unk && !bus.err_clr);
            r_err_ovf <= w_overflow || (r_err_ovf && !bus.err_clr);
            r_err_to  <= w_timeout  || (r_err_to  && !bus.err_clr);
            if (w_unknown || w_timeout) begin
                r_err_op <= w_head;
            end
        end
    end

    assign bus.CMD          = r_cmd;
    assign bus.pkt_accept   = !w_full;
    assign bus.fifo_level   = r_count;
    assign bus.err_unknown  = r_err_unk;
    assign bus.err_overflow = r_err_ovf;
    assign bus.err_timeout  = r_err_to;
    assign bus.err_opcode   = r_err_op;
endmodule

// File: tb/tb_cmd_dispatch.sv
// Bench for cmd_dispatch: decode vector table, hand-written multi-cycle
// sequences, and a long randomized run against a queue-based reference model.
module tb_cmd_dispatch;
    localparam int         NUM_CH      = 8;
    localparam int         OP_W        = 8;
    localparam int         OP_BASE     = 1;
    localparam logic [7:0] VALID_MASK  = 8'hF7;
    localparam logic [7:0] BYPASS_MASK = 8'h01;
    localparam int         FIFO_DEPTH  = 4;
    localparam int         TIMEOUT     = 16;

    logic CLK = 1'b0;
    logic rst = 1'b1;
    always #5 CLK = ~CLK;

    cmd_dispatch_if #(.NUM_CH(NUM_CH), .OP_W(OP_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    cmd_dispatch #(
        .NUM_CH(NUM_CH), .OP_W(OP_W), .OP_BASE(OP_BASE), .VALID_MASK(VALID_MASK),
        .BYPASS_MASK(BYPASS_MASK), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are read 1 time unit after the rising edge
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic pkt(input logic [7:0] op);
        bus.packet_ready = 1'b1;
        bus.opcode       = op;
        cyc();
        bus.packet_ready = 1'b0;
    endtask

    // ---------------- reference model ----------------
    logic [7:0] mq[$];
    int         m_stall;
    int         m_last;
    logic       m_eu, m_eo, m_et;
    logic [7:0] m_eop;
    logic [7:0] m_cmd;

    function void model_reset();
        mq.delete();
        m_stall = 0;
        m_last  = -1;
        m_eu = 1'b0; m_eo = 1'b0; m_et = 1'b0;
        m_eop = 8'h00;
        m_cmd = 8'h00;
    endfunction

    // One clock of behaviour: the head is discarded, issued, timed out or waits; then the arrival is queued
    function void model_step(input logic pr, input logic [7:0] op, input logic [7:0] busy,
                             input logic fl, input logic ec);
        logic ue, oe, te, known, full;
        int   k, issued;
        ue = 1'b0; oe = 1'b0; te = 1'b0;
        issued = -1;
        m_cmd = 8'h00;
        full = (mq.size() == FIFO_DEPTH);
        if (fl) begin
            mq.delete();
            m_stall = 0;
        end else begin
            if (mq.size() != 0) begin
                k = int'(mq[0]) - OP_BASE;
                known = (k >= 0 && k < NUM_CH) ? VALID_MASK[k] : 1'b0;
                if (!known) begin
                    ue = 1'b1; m_eop = mq[0]; void'(mq.pop_front()); m_stall = 0;
                end else if (BYPASS_MASK[k] || (!busy[k] && m_last != k)) begin
                    m_cmd[k] = 1'b1; issued = k; void'(mq.pop_front()); m_stall = 0;
                end else if (m_stall == TIMEOUT - 1) begin
                    te = 1'b1; m_eop = mq[0]; void'(mq.pop_front()); m_stall = 0;
                end else begin
                    m_stall++;
                end
            end
            if (pr) begin
                if (full) oe = 1'b1;
                else mq.push_back(op);
            end
        end
        m_last = issued;
        m_eu = ue || (m_eu && !ec);
        m_eo = oe || (m_eo && !ec);
        m_et = te || (m_et && !ec);
    endfunction

    task automatic check_model(input string tag);
        chk({tag, "_cmd"},    32'(bus.CMD),          32'(m_cmd));
        chk({tag, "_accept"}, 32'(bus.pkt_accept),   32'(mq.size() < FIFO_DEPTH));
        chk({tag, "_level"},  32'(bus.fifo_level),   32'(mq.size()));
        chk({tag, "_eunk"},   32'(bus.err_unknown),  32'(m_eu));
        chk({tag, "_eovf"},   32'(bus.err_overflow), 32'(m_eo));
        chk({tag, "_eto"},    32'(bus.err_timeout),  32'(m_et));
        chk({tag, "_eop"},    32'(bus.err_opcode),   32'(m_eop));
    endtask

    typedef struct {
        logic [7:0] op;
        logic [7:0] busy;
        logic [7:0] exp_cmd;
        logic       exp_unk;
    } vec_t;

    vec_t       vecs [12];
    logic [7:0] seq3 [7];
    logic       pr_v, fl_v, ec_v, rs_v;
    logic [7:0] op_v, busy_v;

    initial begin
        vecs[0]  = '{8'h01, 8'hFF, 8'h01, 1'b0};
        vecs[1]  = '{8'h02, 8'h00, 8'h02, 1'b0};
        vecs[2]  = '{8'h03, 8'h00, 8'h04, 1'b0};
        vecs[3]  = '{8'h04, 8'h00, 8'h00, 1'b1};
        vecs[4]  = '{8'h05, 8'hEF, 8'h10, 1'b0};
        vecs[5]  = '{8'h06, 8'h00, 8'h20, 1'b0};
        vecs[6]  = '{8'h07, 8'h00, 8'h40, 1'b0};
        vecs[7]  = '{8'h08, 8'h7F, 8'h80, 1'b0};
        vecs[8]  = '{8'h00, 8'h00, 8'h00, 1'b1};
        vecs[9]  = '{8'h09, 8'h00, 8'h00, 1'b1};
        vecs[10] = '{8'hFF, 8'h00, 8'h00, 1'b1};
        vecs[11] = '{8'h81, 8'h00, 8'h00, 1'b1};
        seq3 = '{8'h00, 8'h01, 8'h01, 8'h04, 8'h00, 8'h04, 8'h00};

        bus.packet_ready = 1'b0;
        bus.opcode       = 8'h00;
        bus.BUSY         = 8'h00;
        bus.flush        = 1'b0;
        bus.err_clr      = 1'b0;

        // Reset state
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_cmd",    32'(bus.CMD),          32'h0);
        chk("rst_accept", 32'(bus.pkt_accept),   32'h1);
        chk("rst_level",  32'(bus.fifo_level),   32'h0);
        chk("rst_errs",   32'({bus.err_unknown, bus.err_overflow, bus.err_timeout}), 32'h0);
        chk("rst_eop",    32'(bus.err_opcode),   32'h0);

        // Decode table: one packet into an idle queue, pulse expected two cycles later
        for (int i = 0; i < 12; i++) begin
            bus.err_clr = 1'b1;
            cyc();
            bus.err_clr = 1'b0;
            bus.BUSY = vecs[i].busy;
            pkt(vecs[i].op);
            cyc();
            chk($sformatf("vec%0d_cmd", i), 32'(bus.CMD), 32'(vecs[i].exp_cmd));
            chk($sformatf("vec%0d_unk", i), 32'(bus.err_unknown), 32'(vecs[i].exp_unk));
            bus.BUSY = 8'h00;
            cyc();
            chk($sformatf("vec%0d_cmd_off", i), 32'(bus.CMD), 32'h0);
            chk($sformatf("vec%0d_level", i),   32'(bus.fifo_level), 32'h0);
        end

        // Idle latency
        do_reset();
        pkt(8'h02);
        chk("lat_level1", 32'(bus.fifo_level), 32'h1);
        chk("lat_cmd_t1", 32'(bus.CMD), 32'h0);
        cyc();
        chk("lat_cmd_t2", 32'(bus.CMD), 32'h02);
        chk("lat_level0", 32'(bus.fifo_level), 32'h0);
        cyc();
        chk("lat_cmd_t3", 32'(bus.CMD), 32'h0);

        // Busy hold: command waits for BUSY[5] to drop
        do_reset();
        bus.BUSY = 8'h20;
        pkt(8'h06);
        for (int i = 1; i <= 9; i++) begin
            cyc();
            chk($sformatf("hold_cmd_t%0d", i + 1), 32'(bus.CMD), 32'h0);
        end
        bus.BUSY = 8'h00;
        cyc();
        chk("hold_cmd_t11", 32'(bus.CMD), 32'h20);
        chk("hold_errs", 32'({bus.err_unknown, bus.err_timeout}), 32'h0);
        cyc();
        chk("hold_cmd_t12", 32'(bus.CMD), 32'h0);

        // Bypass back-to-back versus hold-off gap
        do_reset();
        bus.packet_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.opcode = (i < 2) ? 8'h01 : 8'h03;
            if (i == 4) bus.packet_ready = 1'b0;
            cyc();
            chk($sformatf("byp_cmd_t%0d", i + 1), 32'(bus.CMD), 32'(seq3[i]));
        end

        // Unknown and masked opcodes
        do_reset();
        bus.packet_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.opcode = (i == 0) ? 8'h04 : (i == 1) ? 8'h00 : 8'h09;
            if (i == 3) bus.packet_ready = 1'b0;
            cyc();
            chk($sformatf("unk_cmd_%0d", i), 32'(bus.CMD), 32'h0);
        end
        chk("unk_flag",  32'(bus.err_unknown), 32'h1);
        chk("unk_eop",   32'(bus.err_opcode),  32'h09);
        chk("unk_level", 32'(bus.fifo_level),  32'h0);
        bus.err_clr = 1'b1;
        cyc();
        bus.err_clr = 1'b0;
        chk("unk_clr", 32'(bus.err_unknown), 32'h0);

        // Overflow, then flush with a same-cycle packet and clear
        do_reset();
        bus.BUSY = 8'h02;
        bus.opcode = 8'h02;
        bus.packet_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk($sformatf("ovf_level_%0d", i),  32'(bus.fifo_level),   (i < 3) ? 32'(i + 1) : 32'h4);
            chk($sformatf("ovf_accept_%0d", i), 32'(bus.pkt_accept),   32'(i < 3));
            chk($sformatf("ovf_flag_%0d", i),   32'(bus.err_overflow), 32'(i >= 4));
        end
        bus.flush   = 1'b1;
        bus.err_clr = 1'b1;
        cyc();
        bus.flush = 1'b0;
        bus.err_clr = 1'b0;
        bus.packet_ready = 1'b0;
        chk("flush_level", 32'(bus.fifo_level),   32'h0);
        chk("flush_ovf",   32'(bus.err_overflow), 32'h0);
        bus.BUSY = 8'h00;
        cyc();
        chk("flush_cmd",    32'(bus.CMD),        32'h0);
        chk("flush_level2", 32'(bus.fifo_level), 32'h0);

        // Stall timeout on a busy channel, then reset with a loaded queue
        do_reset();
        bus.BUSY = 8'h10;
        pkt(8'h05);
        for (int i = 1; i <= 15; i++) cyc();
        chk("to_before_flag",  32'(bus.err_timeout), 32'h0);
        chk("to_before_level", 32'(bus.fifo_level),  32'h1);
        cyc();
        chk("to_flag",  32'(bus.err_timeout), 32'h1);
        chk("to_eop",   32'(bus.err_opcode),  32'h05);
        chk("to_level", 32'(bus.fifo_level),  32'h0);
        chk("to_cmd",   32'(bus.CMD),         32'h0);
        for (int i = 0; i < 3; i++) pkt(8'h05);
        chk("rstq_level_pre", 32'(bus.fifo_level), 32'h3);
        bus.BUSY = 8'h00;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rstq_level", 32'(bus.fifo_level), 32'h0);
        chk("rstq_cmd",   32'(bus.CMD),        32'h0);
        chk("rstq_eto",   32'(bus.err_timeout), 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("rstq_cmd_after%0d", i), 32'(bus.CMD), 32'h0);
        end

        // Randomized run against the reference model
        model_reset();
        do_reset();
        busy_v = 8'h00;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 19) == 0)
                busy_v = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            pr_v = ($urandom_range(0, 99) < 55);
            op_v = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
            fl_v = ($urandom_range(0, 49) == 0);
            ec_v = ($urandom_range(0, 19) == 0);
            rs_v = ($urandom_range(0, 499) == 0);
            bus.packet_ready = pr_v;
            bus.opcode       = op_v;
            bus.BUSY         = busy_v;
            bus.flush        = fl_v;
            bus.err_clr      = ec_v;
            rst              = rs_v;
            if (rs_v) model_reset();
            else model_step(pr_v, op_v, busy_v, fl_v, ec_v);
            cyc();
            check_model($sformatf("rnd%0d", c));
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
